// File: rtl/risc_pkg.sv
// Shared constants for the RISC control unit: opcodes, branch condition codes,
// FSM state encoding and flag bit positions within the latched {C,V,Z,N} register.
package risc_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_LLI = 5'b00001;
    localparam logic [4:0] OP_LHI = 5'b00010;
    localparam logic [4:0] OP_LDR = 5'b00011;
    localparam logic [4:0] OP_STR = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_CMP = 5'b01000;
    localparam logic [4:0] OP_MOV = 5'b01001;
    localparam logic [4:0] OP_BCC = 5'b11000;
    localparam logic [4:0] OP_JMP = 5'b11001;
    localparam logic [4:0] OP_OUT = 5'b11100;
    localparam logic [4:0] OP_HLT = 5'b11111;

    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_NE = 3'b001;
    localparam logic [2:0] CC_CS = 3'b010;
    localparam logic [2:0] CC_CC = 3'b011;
    localparam logic [2:0] CC_MI = 3'b100;
    localparam logic [2:0] CC_PL = 3'b101;
    localparam logic [2:0] CC_VS = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Instructions whose ALU result flags are captured into the flags register.
    function automatic logic is_flag_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
               (op == OP_SBB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/risc_cond_eval.sv
// Branch condition evaluation: maps a 3-bit condition code and the latched
// {C,V,Z,N} flags to a taken/not-taken decision.
module risc_cond_eval
    import risc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken =  flags[FLAG_Z];
            CC_NE:   taken = ~flags[FLAG_Z];
            CC_CS:   taken =  flags[FLAG_C];
            CC_CC:   taken = ~flags[FLAG_C];
            CC_MI:   taken =  flags[FLAG_N];
            CC_PL:   taken = ~flags[FLAG_N];
            CC_VS:   taken =  flags[FLAG_V];
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Sequencing FSM and single-cycle instruction decoder for the RISC datapath.
// Optional macro CTRL_INSTR_COUNT_EN adds a 16-bit executed-instruction counter.
//
// state | meaning
// LOAD  | external memory load, datapath idle
// INIT  | one-cycle datapath PC clear
// RUN   | decode one instruction per cycle
// HALT  | stopped after HLT until test_normal returns
module risc_control_unit
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        test_normal,
    input  logic [15:0] mem_instr_out,
    input  logic        Pre_C,
    input  logic        Pre_V,
    input  logic        Pre_Z,
    input  logic        Pre_N,
    output logic        dp_clr,
    output logic        flag_HLT,
    output logic        ADC,
    output logic        SUB,
    output logic        SBB,
    output logic        JMP,
    output logic        BRANCH,
    output logic        Src_ALU_B,
    output logic        Src_Read_B,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic        flag_Rd_PC,
    output logic        flag_mem_RF,
    output logic        flag_ALU_RF,
    output logic        flag_Rm_RF,
    output logic        flag_PC_RF,
    output logic        RF_write_en,
    output logic        data_write_en,
    output logic        LHI,
    output logic        LLI,
    output logic        flag_OutR,
    output logic [3:0]  flags,
    output logic        illegal_op
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    logic [1:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [4:0] opcode;
    logic [2:0] cond;
    logic       in_run;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode            = mem_instr_out[15:11];
    assign cond              = mem_instr_out[10:8];
    assign in_run            = (state_q == ST_RUN);
    assign unused_instr_bits = ^mem_instr_out[7:0];

    risc_cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags_q),
        .taken (br_taken)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (!test_normal) state_d = ST_INIT;
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (test_normal)
                    state_d = ST_LOAD;
                else if (opcode == OP_HLT)
                    state_d = ST_HALT;
            end
            ST_HALT: if (test_normal) state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (in_run && is_flag_op(opcode))
            flags_d = {Pre_C, Pre_V, Pre_Z, Pre_N};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_LOAD;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign flags  = flags_q;
    assign dp_clr = (state_q == ST_INIT);

    // Everything below is gated by RUN, so reset clears the outputs asynchronously
    // through state_q and a HLT drops flag_HLT within its own cycle.
    always_comb begin
        flag_HLT      = 1'b0;
        ADC           = 1'b0;
        SUB           = 1'b0;
        SBB           = 1'b0;
        JMP           = 1'b0;
        BRANCH        = 1'b0;
        Src_ALU_B     = 1'b0;
        Src_Read_B    = 1'b0;
        flag_label_PC = 1'b0;
        flag_Rm_PC    = 1'b0;
        flag_Rd_PC    = 1'b0;
        flag_mem_RF   = 1'b0;
        flag_ALU_RF   = 1'b0;
        flag_Rm_RF    = 1'b0;
        flag_PC_RF    = 1'b0;
        RF_write_en   = 1'b0;
        data_write_en = 1'b0;
        LHI           = 1'b0;
        LLI           = 1'b0;
        flag_OutR     = 1'b0;
        illegal_op    = 1'b0;
        if (in_run) begin
            flag_HLT = (opcode != OP_HLT);
            case (opcode)
                OP_ADD: begin
                    flag_ALU_RF = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_LLI: begin
                    LLI         = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_LHI: begin
                    LHI         = 1'b1;
                    Src_Read_B  = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_LDR: begin
                    Src_ALU_B   = 1'b1;
                    flag_mem_RF = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_STR: begin
                    Src_ALU_B     = 1'b1;
                    data_write_en = 1'b1;
                end
                OP_ADC: begin
                    ADC         = 1'b1;
                    flag_ALU_RF = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_SUB: begin
                    SUB         = 1'b1;
                    flag_ALU_RF = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_SBB: begin
                    SBB         = 1'b1;
                    flag_ALU_RF = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_CMP: SUB = 1'b1;
                OP_MOV: begin
                    flag_Rm_RF  = 1'b1;
                    RF_write_en = 1'b1;
                end
                OP_BCC: begin
                    BRANCH        = br_taken;
                    flag_label_PC = br_taken;
                end
                OP_JMP: begin
                    JMP        = 1'b1;
                    flag_Rm_PC = 1'b1;
                end
                OP_OUT:  flag_OutR  = 1'b1;
                OP_HLT:  ;
                default: illegal_op = 1'b1;
            endcase
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ST_INIT)
            count_d = 16'h0000;
        else if (in_run && (opcode != OP_HLT))
            count_d = count_q + 16'h0001;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            count_q <= 16'h0000;
        else
            count_q <= count_d;
    end

    assign instr_count = count_q;
`endif

endmodule
